izh_array: RTL
==============

IZH_ARRAY -- requirements
Module: izh_array

Interface
REQ-001 SHALL take parameter N, default 4: number of time-multiplexed neurons (1..64).
REQ-002 SHALL take parameter WIDTH, default 16: signed state/current word width.
REQ-003 SHALL take parameter FRAC, default 7: fractional bits of the fixed-point format.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have ports cur_we, input, 1 bit; cur_addr, input, clog2(N) bits; cur_data, input, WIDTH bits: signed current write.
REQ-007 SHALL have ports mode_we, input, 1 bit; mode_data, input, 2 bits: mode write, addressed by cur_addr (0=RS, 1=IB, 2=CH, 3=FS).
REQ-008 SHALL have ports step, input, 1 bit; busy, output, 1 bit; done, output, 1 bit: sweep start, sweep active, one-cycle sweep-complete pulse.
REQ-009 SHALL have ports spike_valid, output, 1 bit; spike_id, output, clog2(N) bits: one-cycle spike event.
REQ-010 SHALL have ports rd_addr, input, clog2(N) bits; v_rd, output, WIDTH bits; u_rd, output, WIDTH bits: registered state readback.

Function
REQ-011 SHALL hold per-neuron v, u, I (WIDTH, signed Q(WIDTH-FRAC).FRAC) and a 2-bit mode in flops.
REQ-012 SHALL implement FSM IDLE->RD->EX->WB, looping over neurons 0..N-1, with 3 cycles per neuron.
REQ-013 SHALL leave IDLE on step==1 and assert busy from the next cycle through the final WB.
REQ-014 SHALL pulse done in the cycle after the last WB and then return to IDLE.
REQ-015 SHALL ignore step while busy.
REQ-016 SHALL accept cur_we and mode_we only in IDLE; writes while busy SHALL be dropped.
REQ-017 SHALL test for a spike in EX using the stored v: if v >= THR, then v'=c[mode] and u'=u+d[mode] (saturated).
REQ-018 SHALL otherwise, in EX, compute v2=(v*v)>>>FRAC and v'=v+((K004*v2)>>>FRAC)+5*v+C140-u+I.
REQ-019 SHALL also compute, in the non-spike case, u'=u+((a*(((b*v)>>>FRAC)-u))>>>FRAC), using the old v.
REQ-020 SHALL evaluate intermediates at 2*WIDTH+4 bits, shift arithmetically (floor), and saturate v' and u' to the WIDTH signed range, never wrapping.
REQ-021 SHALL write v' and u' back in WB; in the same WB cycle, a spiking neuron SHALL drive spike_valid=1 and spike_id=index.
REQ-022 SHALL keep spike_valid at 0 in all other cycles.
REQ-023 SHALL register v_rd/u_rd from rd_addr with 1-cycle latency; readback SHALL be valid in any state.
REQ-024 SHALL return the pre-WB value when a readback of neuron k coincides with neuron k's WB cycle.

Reset
REQ-025 SHALL, on reset_n==0 at a clock edge: set FSM=IDLE, busy=0, done=0, spike_valid=0, spike_id=0, v_rd=0 and u_rd=0.
REQ-026 SHALL, on the same reset, set every mode=RS, I=0, v=c_RS (-8320 at FRAC=7) and u=(b*c_RS)>>>FRAC (-1690 at FRAC=7).
REQ-027 SHALL let a reset asserted mid-sweep abort the sweep, with no done pulse and no further WB.

Structure
REQ-028 SHALL place in package izh_pkg: the mode enum, FSM state enum, and per-mode a/b/c/d tables.
REQ-029 SHALL also place in izh_pkg: THR(30), K004(0.04), C140(140), all as functions of FRAC.
REQ-030 SHALL use the FRAC=7 table values: a RS/IB/CH=3, FS=13; b=26; c RS/FS=-8320, IB=-7040, CH=-6400; d RS=1024, IB=512, CH/FS=256; THR=3840; K004=5; C140=17920.
REQ-031 SHALL isolate the EX datapath as combinational sub-module izh_update (v, u, I, mode in; v', u', spike out).

Verification
REQ-032 Reset then read all addresses -> v_rd=-8320, u_rd=-1690 for every neuron; busy=0.
REQ-033 N=4, I=0 on all neurons, step once -> busy for 12 cycles, done pulses exactly once, no spike_valid.
REQ-034 Neuron 0 given I=32767 (RS), step -> v_rd(0)=23582, u_rd(0)=-1690; second step -> spike_valid with spike_id=0, then v=-8320, u=-666.
REQ-035 Neuron 2 set to mode FS, forced to spike as in REQ-034 -> u increases by 256 at the spike step, v=-8320.
REQ-036 Pulse step while busy, and cur_we while busy -> no sweep restart, I unchanged, done pulses exactly once.
REQ-037 Assert reset_n=0 during neuron 1's EX -> no done pulse, state returns to reset values, spike_valid=0.

Source files
------------

// File: rtl/izh_pkg.sv
// ---------------------------------------------------------------------------
// izh_pkg
// Shared types and fixed-point constants for the Izhikevich neuron array.
// All constants are returned as ints scaled by 2**frac so the same package
// serves any fractional width. Fractional coefficients are rounded to the
// nearest LSB. Whole-number constants are exact shifts.
//
// Contents:
//   izh_mode_e   - neuron firing mode (RS, IB, CH, FS)
//   izh_state_e  - sweep FSM state
//   izh_thr      - spike threshold (30)
//   izh_k004     - quadratic coefficient (0.04)
//   izh_c140     - constant drive term (140)
//   izh_a/b/c/d  - per-mode recovery and reset parameters
// ---------------------------------------------------------------------------
package izh_pkg;

    typedef enum logic [1:0] {
        MODE_RS = 2'd0,
        MODE_IB = 2'd1,
        MODE_CH = 2'd2,
        MODE_FS = 2'd3
    } izh_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_EX   = 2'd2,
        S_WB   = 2'd3
    } izh_state_e;

    // round(num/den * 2**frac) for non-negative ratios
    function automatic int izh_fx(input int num, input int den, input int frac);
        return ((num <<< frac) + den / 2) / den;
    endfunction

    function automatic int izh_thr(input int frac);
        return 30 <<< frac;
    endfunction

    function automatic int izh_k004(input int frac);
        return izh_fx(4, 100, frac);
    endfunction

    function automatic int izh_c140(input int frac);
        return 140 <<< frac;
    endfunction

    // recovery time scale
    function automatic int izh_a(input izh_mode_e mode, input int frac);
        int r;
        case (mode)
            MODE_FS: r = izh_fx(10, 100, frac);
            default: r = izh_fx(2, 100, frac);
        endcase
        return r;
    endfunction

    // recovery sensitivity, identical for all modes
    function automatic int izh_b(input int frac);
        return izh_fx(20, 100, frac);
    endfunction

    // post-spike membrane reset value
    function automatic int izh_c(input izh_mode_e mode, input int frac);
        int r;
        case (mode)
            MODE_IB: r = -(55 <<< frac);
            MODE_CH: r = -(50 <<< frac);
            default: r = -(65 <<< frac);
        endcase
        return r;
    endfunction

    // post-spike recovery increment
    function automatic int izh_d(input izh_mode_e mode, input int frac);
        int r;
        case (mode)
            MODE_RS: r = 8 <<< frac;
            MODE_IB: r = 4 <<< frac;
            default: r = 2 <<< frac;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/izh_array_update.sv
// ---------------------------------------------------------------------------
// izh_update
// Combinational single-neuron Izhikevich step in signed fixed point.
// All intermediates are carried at 2*WIDTH+4 bits so no product can wrap.
// Shifts are arithmetic, so they floor. Both results are clamped to the
// WIDTH signed range.
//
// Ports:
//   v, u    - current membrane / recovery state
//   cur     - input current I
//   mode    - firing mode selecting a/c/d
//   v_next  - updated membrane state
//   u_next  - updated recovery state
//   spike   - stored v was at or above threshold
// ---------------------------------------------------------------------------
module izh_update
    import izh_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 7
) (
    input  logic signed [WIDTH-1:0] v,
    input  logic signed [WIDTH-1:0] u,
    input  logic signed [WIDTH-1:0] cur,
    input  izh_mode_e               mode,
    output logic signed [WIDTH-1:0] v_next,
    output logic signed [WIDTH-1:0] u_next,
    output logic                    spike
);

    localparam int IW = 2 * WIDTH + 4;

    localparam logic signed [IW-1:0] SMAX = {{(IW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0] SMIN = {{(IW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [IW-1:0] THR_X  = IW'(izh_thr(FRAC));
    localparam logic signed [IW-1:0] K004_X = IW'(izh_k004(FRAC));
    localparam logic signed [IW-1:0] C140_X = IW'(izh_c140(FRAC));
    localparam logic signed [IW-1:0] B_X    = IW'(izh_b(FRAC));
    localparam logic signed [IW-1:0] FIVE_X = IW'(5);

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] x);
        logic signed [IW-1:0] y;
        if (x > SMAX)
            y = SMAX;
        else if (x < SMIN)
            y = SMIN;
        else
            y = x;
        return WIDTH'(y);
    endfunction

    logic signed [IW-1:0] vx, ux, ix;
    logic signed [IW-1:0] a_x, c_x, d_x;
    logic signed [IW-1:0] v2, quad, v_sum;
    logic signed [IW-1:0] bv, du, u_sum;

    always_comb begin
        vx = IW'(v);
        ux = IW'(u);
        ix = IW'(cur);
        a_x = IW'(izh_a(mode, FRAC));
        c_x = IW'(izh_c(mode, FRAC));
        d_x = IW'(izh_d(mode, FRAC));

        // Threshold test looks at the stored v, not the freshly integrated one.
        spike = (vx >= THR_X);

        v2    = (vx * vx) >>> FRAC;
        quad  = (K004_X * v2) >>> FRAC;
        v_sum = vx + quad + FIVE_X * vx + C140_X - ux + ix;

        bv    = (B_X * vx) >>> FRAC;
        du    = (a_x * (bv - ux)) >>> FRAC;
        u_sum = ux + du;

        if (spike) begin
            v_next = sat(c_x);
            u_next = sat(ux + d_x);
        end else begin
            v_next = sat(v_sum);
            u_next = sat(u_sum);
        end
    end

endmodule

// File: rtl/izh_array.sv
// ---------------------------------------------------------------------------
// izh_array
// Time-multiplexed array of N Izhikevich neurons sharing one update datapath.
// A step pulse in IDLE starts a sweep: each neuron takes RD (fetch operands),
// EX (compute and register result) and WB (commit, report spike). Host writes
// of current and mode are only honoured while idle.
//
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   cur_we/cur_addr/data  - write input current of neuron cur_addr
//   mode_we/mode_data     - write firing mode of neuron cur_addr
//   step                  - start a sweep (ignored while busy)
//   busy                  - sweep in progress (RD/EX/WB)
//   done                  - one-cycle pulse after the final WB
//   spike_valid/spike_id  - one-cycle spike event during a neuron's WB
//   rd_addr, v_rd, u_rd   - registered state readback, 1-cycle latency
// ---------------------------------------------------------------------------
module izh_array
    import izh_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 16,
    parameter  int FRAC  = 7,
    localparam int AW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cur_we,
    input  logic [AW-1:0]           cur_addr,
    input  logic signed [WIDTH-1:0] cur_data,
    input  logic                    mode_we,
    input  logic [1:0]              mode_data,
    input  logic                    step,
    output logic                    busy,
    output logic                    done,
    output logic                    spike_valid,
    output logic [AW-1:0]           spike_id,
    input  logic [AW-1:0]           rd_addr,
    output logic signed [WIDTH-1:0] v_rd,
    output logic signed [WIDTH-1:0] u_rd
);

    // Storage is rounded up to a power of two so every address decodes;
    // entries at or beyond N are never swept.
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    localparam logic signed [WIDTH-1:0] V_RST = WIDTH'(izh_c(MODE_RS, FRAC));
    localparam logic signed [WIDTH-1:0] U_RST =
        WIDTH'((izh_b(FRAC) * izh_c(MODE_RS, FRAC)) >>> FRAC);

    izh_state_e state, state_nxt;
    logic [AW-1:0] idx;

    logic signed [WIDTH-1:0] v_mem [DEPTH];
    logic signed [WIDTH-1:0] u_mem [DEPTH];
    logic signed [WIDTH-1:0] i_mem [DEPTH];
    izh_mode_e               m_mem [DEPTH];

    logic signed [WIDTH-1:0] v_op, u_op, i_op;
    izh_mode_e               m_op;
    logic signed [WIDTH-1:0] v_new, u_new, v_res, u_res;
    logic                    spk_new, spk_r;

    izh_update #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_update (
        .v      (v_op),
        .u      (u_op),
        .cur    (i_op),
        .mode   (m_op),
        .v_next (v_new),
        .u_next (u_new),
        .spike  (spk_new)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state and decoded outputs
    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        spike_valid = 1'b0;
        spike_id    = '0;
        case (state)
            S_IDLE: begin
                if (step)
                    state_nxt = S_RD;
            end
            S_RD: begin
                busy      = 1'b1;
                state_nxt = S_EX;
            end
            S_EX: begin
                busy      = 1'b1;
                state_nxt = S_WB;
            end
            S_WB: begin
                busy        = 1'b1;
                spike_valid = spk_r;
                spike_id    = spk_r ? idx : '0;
                state_nxt   = (idx == LAST) ? S_IDLE : S_RD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Neuron state, pipeline registers and readback
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx   <= '0;
            done  <= 1'b0;
            v_rd  <= '0;
            u_rd  <= '0;
            v_op  <= '0;
            u_op  <= '0;
            i_op  <= '0;
            m_op  <= MODE_RS;
            v_res <= '0;
            u_res <= '0;
            spk_r <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                v_mem[k] <= V_RST;
                u_mem[k] <= U_RST;
                i_mem[k] <= '0;
                m_mem[k] <= MODE_RS;
            end
        end else begin
            done <= (state == S_WB) && (idx == LAST);
            // Sampled before this edge's WB lands, so a coinciding read
            // returns the pre-update value.
            v_rd <= v_mem[rd_addr];
            u_rd <= u_mem[rd_addr];

            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (cur_we)
                        i_mem[cur_addr] <= cur_data;
                    if (mode_we)
                        m_mem[cur_addr] <= izh_mode_e'(mode_data);
                end
                S_RD: begin
                    v_op <= v_mem[idx];
                    u_op <= u_mem[idx];
                    i_op <= i_mem[idx];
                    m_op <= m_mem[idx];
                end
                S_EX: begin
                    v_res <= v_new;
                    u_res <= u_new;
                    spk_r <= spk_new;
                end
                S_WB: begin
                    v_mem[idx] <= v_res;
                    u_mem[idx] <= u_res;
                    idx <= (idx == LAST) ? '0 : idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
